// File: rtl/spi_frame_parser.sv
// Assembles SPI chip-select frames (address byte + little-endian 32-bit words)
// into register-file writes, with clean/malformed frame diagnostics counters.
module spi_frame_parser #(
   parameter int unsigned MAX_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rxd,
   input  logic        rxdv,
   input  logic        rxe,
   output logic [7:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_en,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_bad
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [1:0]      idx_q, idx_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   sh_q, sh_d;
   logic [DW-1:0]   word_c;
   logic [AW-1:0]   wr_addr_d;
   logic [DW-1:0]   wr_data_d;
   logic            wr_en_d, done_d, err_d;
   logic [CW-1:0]   ok_d, bad_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         sh_q       <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frames_ok  <= '0;
         frames_bad <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         wr_en      <= wr_en_d;
         frame_done <= done_d;
         frame_err  <= err_d;
         frames_ok  <= ok_d;
         frames_bad <= bad_d;
      end
   end

   // Next-state: the byte is applied first, then end-of-frame sees the post-byte state
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      ok_d      = frames_ok;
      bad_d     = frames_bad;

      word_c = sh_q;
      case (idx_q)
         2'd0:    word_c[7:0]   = rxd;
         2'd1:    word_c[15:8]  = rxd;
         2'd2:    word_c[23:16] = rxd;
         default: word_c[31:24] = rxd;
      endcase

      if (rxdv) begin
         case (state_q)
            IDLE: begin
               addr_d  = rxd;
               idx_d   = 2'd0;
               cnt_d   = '0;
               state_d = DATA;
            end
            DATA: begin
               if (cnt_q == AW'(MAX_WORDS)) begin
                  state_d = DROP;
               end else begin
                  sh_d  = word_c;
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = word_c;
                     wr_addr_d = addr_q;
                     addr_d    = addr_q + AW'(1);
                     cnt_d     = cnt_q + AW'(1);
                  end
               end
            end
            default: ;
         endcase
      end

      if (rxe) begin
         case (state_d)
            DATA: begin
               if (idx_d == 2'd0) begin
                  done_d = 1'b1;
                  ok_d   = frames_ok + CW'(1);
               end else begin
                  err_d = 1'b1;
                  bad_d = frames_bad + CW'(1);
               end
               state_d = IDLE;
            end
            DROP: begin
               err_d   = 1'b1;
               bad_d   = frames_bad + CW'(1);
               state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_parser.sv
// Directed, table-driven bench for spi_frame_parser (MAX_WORDS=2), plus a
// hand-written mid-frame reset sequence.
module tb_spi_frame_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rxd = '0;
   logic        rxdv = 1'b0;
   logic        rxe = 1'b0;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_en, frame_done, frame_err;
   logic [15:0] frames_ok, frames_bad;

   always #5 clk = ~clk;

   spi_frame_parser #(.MAX_WORDS(2)) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .rxdv(rxdv), .rxe(rxe),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .frame_done(frame_done), .frame_err(frame_err),
      .frames_ok(frames_ok), .frames_bad(frames_bad)
   );

   typedef struct {
      string       name;
      logic [7:0]  rxd;
      logic        dv, e;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        done, err;
      logic [15:0] ok, bad;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input string nm, input logic [7:0] b, input logic dv, input logic e,
                      input logic we, input logic [7:0] a, input logic [31:0] d,
                      input logic dn, input logic er, input logic [15:0] ok, input logic [15:0] bad);
      vec_t v;
      v.name = nm; v.rxd = b; v.dv = dv; v.e = e; v.we = we; v.addr = a; v.data = d;
      v.done = dn; v.err = er; v.ok = ok; v.bad = bad;
      vq.push_back(v);
   endtask

   // Byte strobe that produces no pulse
   task automatic byt(input string nm, input logic [7:0] b, input logic [7:0] a,
                      input logic [31:0] d, input logic [15:0] ok, input logic [15:0] bad);
      add(nm, b, 1'b1, 1'b0, 1'b0, a, d, 1'b0, 1'b0, ok, bad);
   endtask

   task automatic chk(input string nm, input vec_t x);
      n_tests++;
      if ({wr_en, wr_addr, wr_data, frame_done, frame_err, frames_ok, frames_bad} !==
          {x.we, x.addr, x.data, x.done, x.err, x.ok, x.bad}) begin
         n_fail++;
         $display("FAIL %s: got we=%0b addr=%h data=%h done=%0b err=%0b ok=%0d bad=%0d; want we=%0b addr=%h data=%h done=%0b err=%0b ok=%0d bad=%0d",
                  nm, wr_en, wr_addr, wr_data, frame_done, frame_err, frames_ok, frames_bad,
                  x.we, x.addr, x.data, x.done, x.err, x.ok, x.bad);
      end
   endtask

   // One strobe cycle, checked 1 clk later, then an idle cycle where pulses must drop
   task automatic step(input vec_t x);
      vec_t g;
      @(negedge clk);
      rxd = x.rxd; rxdv = x.dv; rxe = x.e;
      @(posedge clk); #1;
      chk(x.name, x);
      @(negedge clk);
      rxd = '0; rxdv = 1'b0; rxe = 1'b0;
      g = x; g.we = 1'b0; g.done = 1'b0; g.err = 1'b0;
      @(posedge clk); #1;
      chk({x.name, "_gap"}, g);
   endtask

   initial begin
      vec_t z;
      vec_t h;
      z.name = "zero"; z.rxd = '0; z.dv = 1'b0; z.e = 1'b0; z.we = 1'b0; z.addr = '0;
      z.data = '0; z.done = 1'b0; z.err = 1'b0; z.ok = '0; z.bad = '0;

      // Basic two-word frame
      byt("t1_hdr", 8'h10, 8'h00, 32'h0, 16'd0, 16'd0);
      byt("t1_b0", 8'h78, 8'h00, 32'h0, 16'd0, 16'd0);
      byt("t1_b1", 8'h56, 8'h00, 32'h0, 16'd0, 16'd0);
      byt("t1_b2", 8'h34, 8'h00, 32'h0, 16'd0, 16'd0);
      add("t1_w0", 8'h12, 1, 0, 1, 8'h10, 32'h12345678, 0, 0, 16'd0, 16'd0);
      byt("t1_b4", 8'hEF, 8'h10, 32'h12345678, 16'd0, 16'd0);
      byt("t1_b5", 8'hBE, 8'h10, 32'h12345678, 16'd0, 16'd0);
      byt("t1_b6", 8'hAD, 8'h10, 32'h12345678, 16'd0, 16'd0);
      add("t1_w1", 8'hDE, 1, 0, 1, 8'h11, 32'hDEADBEEF, 0, 0, 16'd0, 16'd0);
      add("t1_eof", 8'h00, 0, 1, 0, 8'h11, 32'hDEADBEEF, 1, 0, 16'd1, 16'd0);
      // Address wrap 0xFF -> 0x00
      byt("t2_hdr", 8'hFF, 8'h11, 32'hDEADBEEF, 16'd1, 16'd0);
      byt("t2_b0", 8'h11, 8'h11, 32'hDEADBEEF, 16'd1, 16'd0);
      byt("t2_b1", 8'h22, 8'h11, 32'hDEADBEEF, 16'd1, 16'd0);
      byt("t2_b2", 8'h33, 8'h11, 32'hDEADBEEF, 16'd1, 16'd0);
      add("t2_w0", 8'h44, 1, 0, 1, 8'hFF, 32'h44332211, 0, 0, 16'd1, 16'd0);
      byt("t2_b4", 8'h55, 8'hFF, 32'h44332211, 16'd1, 16'd0);
      byt("t2_b5", 8'h66, 8'hFF, 32'h44332211, 16'd1, 16'd0);
      byt("t2_b6", 8'h77, 8'hFF, 32'h44332211, 16'd1, 16'd0);
      add("t2_w1", 8'h88, 1, 0, 1, 8'h00, 32'h88776655, 0, 0, 16'd1, 16'd0);
      add("t2_eof", 8'h00, 0, 1, 0, 8'h00, 32'h88776655, 1, 0, 16'd2, 16'd0);
      // Partial word at end of frame
      byt("t3_hdr", 8'h20, 8'h00, 32'h88776655, 16'd2, 16'd0);
      byt("t3_b0", 8'h01, 8'h00, 32'h88776655, 16'd2, 16'd0);
      byt("t3_b1", 8'h02, 8'h00, 32'h88776655, 16'd2, 16'd0);
      byt("t3_b2", 8'h03, 8'h00, 32'h88776655, 16'd2, 16'd0);
      add("t3_eof", 8'h00, 0, 1, 0, 8'h00, 32'h88776655, 0, 1, 16'd2, 16'd1);
      // Overflow past MAX_WORDS=2
      byt("t4_hdr", 8'h00, 8'h00, 32'h88776655, 16'd2, 16'd1);
      byt("t4_a0", 8'hA0, 8'h00, 32'h88776655, 16'd2, 16'd1);
      byt("t4_a1", 8'hA1, 8'h00, 32'h88776655, 16'd2, 16'd1);
      byt("t4_a2", 8'hA2, 8'h00, 32'h88776655, 16'd2, 16'd1);
      add("t4_w0", 8'hA3, 1, 0, 1, 8'h00, 32'hA3A2A1A0, 0, 0, 16'd2, 16'd1);
      byt("t4_b0", 8'hB0, 8'h00, 32'hA3A2A1A0, 16'd2, 16'd1);
      byt("t4_b1", 8'hB1, 8'h00, 32'hA3A2A1A0, 16'd2, 16'd1);
      byt("t4_b2", 8'hB2, 8'h00, 32'hA3A2A1A0, 16'd2, 16'd1);
      add("t4_w1", 8'hB3, 1, 0, 1, 8'h01, 32'hB3B2B1B0, 0, 0, 16'd2, 16'd1);
      byt("t4_c0", 8'hC0, 8'h01, 32'hB3B2B1B0, 16'd2, 16'd1);
      byt("t4_c1", 8'hC1, 8'h01, 32'hB3B2B1B0, 16'd2, 16'd1);
      byt("t4_c2", 8'hC2, 8'h01, 32'hB3B2B1B0, 16'd2, 16'd1);
      byt("t4_c3", 8'hC3, 8'h01, 32'hB3B2B1B0, 16'd2, 16'd1);
      add("t4_eof", 8'h00, 0, 1, 0, 8'h01, 32'hB3B2B1B0, 0, 1, 16'd2, 16'd2);
      // Stray rxe in IDLE, then header-only frame
      add("t5_idle_eof", 8'h00, 0, 1, 0, 8'h01, 32'hB3B2B1B0, 0, 0, 16'd2, 16'd2);
      byt("t5_hdr", 8'h40, 8'h01, 32'hB3B2B1B0, 16'd2, 16'd2);
      add("t5_eof", 8'h00, 0, 1, 0, 8'h01, 32'hB3B2B1B0, 1, 0, 16'd3, 16'd2);
      // Word-completing byte coincident with rxe; header coincident with rxe
      byt("t6_hdr", 8'h30, 8'h01, 32'hB3B2B1B0, 16'd3, 16'd2);
      byt("t6_b0", 8'h01, 8'h01, 32'hB3B2B1B0, 16'd3, 16'd2);
      byt("t6_b1", 8'h02, 8'h01, 32'hB3B2B1B0, 16'd3, 16'd2);
      byt("t6_b2", 8'h03, 8'h01, 32'hB3B2B1B0, 16'd3, 16'd2);
      add("t6_w_eof", 8'h04, 1, 1, 1, 8'h30, 32'h04030201, 1, 0, 16'd4, 16'd2);
      add("t6_hdr_eof", 8'h50, 1, 1, 0, 8'h30, 32'h04030201, 1, 0, 16'd5, 16'd2);

      // Reset state
      repeat (3) @(posedge clk);
      #1 chk("reset_hold", z);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 chk("reset_release", z);

      foreach (vq[i]) step(vq[i]);

      // Mid-frame reset abandons the frame and clears counters
      h = z;
      h.dv = 1'b1; h.addr = 8'h30; h.data = 32'h04030201; h.ok = 16'd5; h.bad = 16'd2;
      h.name = "t7_hdr"; h.rxd = 8'h60; step(h);
      h.name = "t7_b0";  h.rxd = 8'h11; step(h);
      h.name = "t7_b1";  h.rxd = 8'h22; step(h);
      @(negedge clk) rst_n = 1'b0;
      #1 chk("t7_rst_async", z);
      @(posedge clk); #1 chk("t7_rst_held", z);
      @(negedge clk) rst_n = 1'b1;
      h = z; h.dv = 1'b1;
      h.name = "t7_hdr2"; h.rxd = 8'h05; step(h);
      h.name = "t7_c0";   h.rxd = 8'h01; step(h);
      h.name = "t7_c1";   h.rxd = 8'h02; step(h);
      h.name = "t7_c2";   h.rxd = 8'h03; step(h);
      h.name = "t7_w0";   h.rxd = 8'h04; h.we = 1'b1; h.addr = 8'h05; h.data = 32'h04030201; step(h);
      h.name = "t7_eof";  h.rxd = 8'h00; h.dv = 1'b0; h.e = 1'b1; h.we = 1'b0; h.done = 1'b1;
      h.ok = 16'd1; step(h);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
